// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter that lets two requesters (A, B) share
// one single-port 2^AW x DW RAM. Each command takes three cycles:
// IDLE (sample and latch), GRANT (RAM access, ack raised), DONE (ack high).
module ram_arbiter #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          ack_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_b,
  output logic [DW-1:0] rdata_b,
  output logic          busy,
  output logic          owner
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
  typedef logic [DW-1:0] mem_t [DEPTH];

  // Power-up image of the byte store; entries beyond 8 start at zero.
  function automatic mem_t mem_init();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      case (i)
        0:       m[i] = DW'(8'h0D);
        1:       m[i] = DW'(8'h82);
        2:       m[i] = DW'(8'h21);
        3:       m[i] = DW'(8'h03);
        4:       m[i] = DW'(8'h50);
        5:       m[i] = DW'(8'h20);
        6:       m[i] = DW'(8'h23);
        7:       m[i] = DW'(8'hF0);
        default: m[i] = '0;
      endcase
    end
    return m;
  endfunction

  // The RAM has no reset: contents persist across rst_n.
  mem_t mem_q = mem_init();

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          cmd_we_q, cmd_we_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;
  logic          pick_b;
  logic          mem_wr_en;

  // Next-state logic: arbitration in IDLE, RAM read-back and ack in GRANT.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    pick_b      = 1'b0;
    mem_wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          // On a tie, grant the port that did not win last time.
          pick_b      = req_b && (!req_a || !owner_q);
          state_d     = GRANT;
          owner_d     = pick_b;
          cmd_we_d    = pick_b ? we_b    : we_a;
          cmd_addr_d  = pick_b ? addr_b  : addr_a;
          cmd_wdata_d = pick_b ? wdata_b : wdata_a;
        end
      end
      GRANT: begin
        state_d   = DONE;
        mem_wr_en = cmd_we_q;
        if (owner_q) begin
          ack_b_d = 1'b1;
          if (!cmd_we_q) rdata_b_d = mem_q[cmd_addr_q];
        end else begin
          ack_a_d = 1'b1;
          if (!cmd_we_q) rdata_a_d = mem_q[cmd_addr_q];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control/command registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b1;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
    end
  end

  // RAM write port; a reset at the GRANT edge cancels the write.
  always_ff @(posedge clk) begin
    if (rst_n && mem_wr_en) mem_q[cmd_addr_q] <= cmd_wdata_q;
  end

  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;
  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign busy    = (state_q != IDLE);
  assign owner   = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset values, latency, arbitration,
// fairness, reset during GRANT and RAM persistence across reset.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, we_a, req_b, we_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       ack_a, ack_b, busy, owner;
  logic [7:0] rdata_a, rdata_b;

  int nchk  = 0;
  int nfail = 0;

  ram_arbiter #(.AW(3), .DW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (req_a),
    .we_a    (we_a),
    .addr_a  (addr_a),
    .wdata_a (wdata_a),
    .ack_a   (ack_a),
    .rdata_a (rdata_a),
    .req_b   (req_b),
    .we_b    (we_b),
    .addr_b  (addr_b),
    .wdata_b (wdata_b),
    .ack_b   (ack_b),
    .rdata_b (rdata_b),
    .busy    (busy),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, wait (bounded) for its ack, drop req during DONE.
  task automatic do_cmd(input bit port, input bit we, input logic [2:0] a, input logic [7:0] d);
    bit got;
    if (!port) begin
      req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d;
    end else begin
      req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d;
    end
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      cyc();
      if ((port ? ack_b : ack_a) === 1'b1) got = 1'b1;
    end
    chk(port ? "ack_b_seen" : "ack_a_seen", 32'(got), 32'd1);
    req_a = 1'b0;
    req_b = 1'b0;
    cyc();
  endtask

  initial begin
    int  nack;
    int  last_t;
    bit  exp_b;
    int  t;

    rst_n = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    cyc();
    cyc();
    chk("rst_ack_a",   32'(ack_a),   32'd0);
    chk("rst_ack_b",   32'(ack_b),   32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_owner",   32'(owner),   32'd1);
    chk("rst_rdata_a", 32'(rdata_a), 32'h00);
    chk("rst_rdata_b", 32'(rdata_b), 32'h00);
    rst_n = 1'b1;

    // A reads addr 7: latched at k, ack at k+1, idle again at k+2.
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd7;
    cyc();
    chk("t1_busy_k",   32'(busy),    32'd1);
    chk("t1_owner_k",  32'(owner),   32'd0);
    chk("t1_ack_a_k",  32'(ack_a),   32'd0);
    cyc();
    chk("t1_ack_a_k1", 32'(ack_a),   32'd1);
    chk("t1_rdata_a",  32'(rdata_a), 32'hF0);
    chk("t1_ack_b",    32'(ack_b),   32'd0);
    chk("t1_rdata_b",  32'(rdata_b), 32'h00);
    req_a = 1'b0;
    cyc();
    chk("t1_ack_a_k2", 32'(ack_a),   32'd0);
    chk("t1_busy_k2",  32'(busy),    32'd0);

    // B writes 5A to addr 3, then A reads it back.
    do_cmd(1'b1, 1'b1, 3'd3, 8'h5A);
    chk("t2_rdata_b_wr", 32'(rdata_b), 32'h00);
    chk("t2_rdata_a_wr", 32'(rdata_a), 32'hF0);
    do_cmd(1'b0, 1'b0, 3'd3, 8'h00);
    chk("t2_rdata_a",    32'(rdata_a), 32'h5A);
    chk("t2_rdata_b",    32'(rdata_b), 32'h00);

    // Simultaneous requests right after reset: A first, then B.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 3'd1;
    cyc();
    chk("t3_owner_a",  32'(owner),   32'd0);
    cyc();
    chk("t3_ack_a",    32'(ack_a),   32'd1);
    chk("t3_ack_b_0",  32'(ack_b),   32'd0);
    chk("t3_rdata_a",  32'(rdata_a), 32'h0D);
    req_a = 1'b0;
    cyc();
    chk("t3_busy_b_wait", 32'(busy), 32'd0);
    cyc();
    chk("t3_owner_b",  32'(owner),   32'd1);
    cyc();
    chk("t3_ack_b",    32'(ack_b),   32'd1);
    chk("t3_rdata_b",  32'(rdata_b), 32'h82);
    chk("t3_rdata_a_kept", 32'(rdata_a), 32'h0D);
    req_b = 1'b0;
    cyc();

    // Both request continuously: 8 grants alternating A,B,... 3 cycles apart.
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd7;
    req_b = 1'b1; we_b = 1'b0; addr_b = 3'd6;
    nack = 0; last_t = 0; exp_b = 1'b0; t = 0;
    while (nack < 8 && t < 60) begin
      cyc();
      t++;
      if (ack_a === 1'b1 || ack_b === 1'b1) begin
        chk("t4_order_a", 32'(ack_a), 32'(!exp_b));
        chk("t4_order_b", 32'(ack_b), 32'(exp_b));
        if (nack > 0) chk("t4_spacing", 32'(t - last_t), 32'd3);
        last_t = t;
        exp_b  = !exp_b;
        nack++;
      end
    end
    chk("t4_ack_count", 32'(nack), 32'd8);
    chk("t4_rdata_a", 32'(rdata_a), 32'hF0);
    chk("t4_rdata_b", 32'(rdata_b), 32'h23);
    req_a = 1'b0;
    req_b = 1'b0;
    cyc();

    // A writes 77 to addr 2, reset lands on the GRANT-closing edge.
    req_a = 1'b1; we_a = 1'b1; addr_a = 3'd2; wdata_a = 8'h77;
    cyc();
    chk("t5_busy_k", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req_a = 1'b0;
    cyc();
    chk("t5_no_ack_a", 32'(ack_a), 32'd0);
    chk("t5_busy_rst", 32'(busy),  32'd0);
    rst_n = 1'b1;
    cyc();
    chk("t5_ack_a_after", 32'(ack_a), 32'd0);
    do_cmd(1'b0, 1'b0, 3'd2, 8'h00);
    chk("t5_rdata_a", 32'(rdata_a), 32'h21);

    // A writes C3 to addr 4, 2-cycle reset, then B reads it back.
    do_cmd(1'b0, 1'b1, 3'd4, 8'hC3);
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("t6_rdata_b_rst", 32'(rdata_b), 32'h00);
    do_cmd(1'b1, 1'b0, 3'd4, 8'h00);
    chk("t6_rdata_b", 32'(rdata_b), 32'hC3);
    chk("t6_owner",   32'(owner),   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
